// File: rtl/trigger_stamp_fifo.sv
// Timestamps sync-qualified triggers with a bunch-crossing counter and queues the event words.
// Build option: define TRIGGER_STAMP_DEADTIME_EN for dead-time suppression and its reject counter.
module trigger_stamp_fifo #(
  parameter int unsigned TS_W       = 23,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk80,
  input  logic                  reset_n,
  input  logic                  sync,
  input  logic                  enable,
  input  logic                  clear_ts,
  input  logic [4:0]            trigger_in,
  input  logic [3:0]            trigger_pos,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [TS_W+8:0]       rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           trg_count,
  output logic [7:0]            ovf_count
`ifdef TRIGGER_STAMP_DEADTIME_EN
  ,
  input  logic [7:0]            deadtime,
  output logic [15:0]           dt_reject_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned WW    = TS_W + 9;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [TS_W-1:0]       bx;
  logic [WW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0]         wr_word, head_nxt;
  logic                  evt, accept, wr_en, drop, pop, full;

  assign wr_word  = {trigger_in, bx, trigger_pos};
  assign evt      = sync & enable & (|trigger_in);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (level == LVL_FULL);
  assign wr_en    = accept & (~full | pop);
  assign drop     = accept & full & ~pop;

`ifdef TRIGGER_STAMP_DEADTIME_EN
  logic [7:0] dt_cnt;

  assign accept = evt & (dt_cnt == '0);

  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      dt_cnt          <= '0;
      dt_reject_count <= '0;
    end else begin
      if (wr_en)
        dt_cnt <= deadtime;
      else if (sync && dt_cnt != '0)
        dt_cnt <= dt_cnt - 8'd1;
      if (evt && dt_cnt != '0)
        dt_reject_count <= dt_reject_count + 16'd1;
    end
  end
`else
  assign accept = evt;
`endif

  always_ff @(posedge clk80) begin
    if (wr_en)
      mem[wr_ptr] <= wr_word;
  end

  // rd_data is a register so it keeps the last popped word once the FIFO drains
  always_comb begin
    head_nxt = rd_data;
    if (pop) begin
      if (level > LVL_ONE)
        head_nxt = mem[rd_ptr + PTR_ONE];
      else if (wr_en)
        head_nxt = wr_word;
    end else if (level == '0 && wr_en) begin
      head_nxt = wr_word;
    end
  end

  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      bx        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      trg_count <= '0;
      ovf_count <= '0;
    end else begin
      if (clear_ts)
        bx <= '0;
      else if (sync)
        bx <= bx + (TS_W)'(1);

      rd_data <= head_nxt;
      if (wr_en) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        trg_count <= trg_count + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      case ({wr_en, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      if (drop && ovf_count != 8'hFF)
        ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_trigger_stamp_fifo.sv
// Bench for trigger_stamp_fifo: directed scenarios plus random traffic against a queue model.
module tb_trigger_stamp_fifo;

  localparam int TS_W  = 23;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int WW    = TS_W + 9;

  logic clk80 = 1'b0;
  logic reset_n = 1'b0;
  logic sync = 1'b0, enable = 1'b0, clear_ts = 1'b0, rd_ready = 1'b0;
  logic [4:0] trigger_in = '0;
  logic [3:0] trigger_pos = '0;
  logic rd_valid;
  logic [WW-1:0] rd_data;
  logic [DL:0] level;
  logic [15:0] trg_count;
  logic [7:0] ovf_count;
  logic [7:0] deadtime = '0;
  logic [15:0] dt_reject_count;

  // small instance used only to exercise timestamp wrap in a few cycles
  logic w_sync = 1'b0, w_rd_ready = 1'b0;
  logic [4:0] w_trig = '0;
  logic [3:0] w_pos = '0;
  logic w_rd_valid;
  logic [12:0] w_rd_data;
  logic [2:0] w_level;
  logic [15:0] w_trg;
  logic [7:0] w_ovf;
  logic [15:0] w_dtrej;

  always #5 clk80 = ~clk80;

  trigger_stamp_fifo #(.TS_W(TS_W), .DEPTH_LOG2(DL)) u_dut (
    .clk80(clk80), .reset_n(reset_n), .sync(sync), .enable(enable), .clear_ts(clear_ts),
    .trigger_in(trigger_in), .trigger_pos(trigger_pos), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .level(level), .trg_count(trg_count),
    .ovf_count(ovf_count)
`ifdef TRIGGER_STAMP_DEADTIME_EN
    , .deadtime(deadtime), .dt_reject_count(dt_reject_count)
`endif
  );

  trigger_stamp_fifo #(.TS_W(4), .DEPTH_LOG2(2)) u_wrap (
    .clk80(clk80), .reset_n(reset_n), .sync(w_sync), .enable(1'b1), .clear_ts(1'b0),
    .trigger_in(w_trig), .trigger_pos(w_pos), .rd_valid(w_rd_valid),
    .rd_ready(w_rd_ready), .rd_data(w_rd_data), .level(w_level), .trg_count(w_trg),
    .ovf_count(w_ovf)
`ifdef TRIGGER_STAMP_DEADTIME_EN
    , .deadtime(8'd0), .dt_reject_count(w_dtrej)
`endif
  );

`ifndef TRIGGER_STAMP_DEADTIME_EN
  assign dt_reject_count = '0;
  assign w_dtrej = '0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model state
  logic [WW-1:0]   m_q[$];
  logic [TS_W-1:0] m_bx;
  logic [15:0]     m_trg;
  logic [7:0]      m_ovf;
  logic [WW-1:0]   m_rd;
  int              m_dt;
  logic [15:0]     m_dtrej;

  task automatic model_reset();
    m_q.delete();
    m_bx = '0; m_trg = '0; m_ovf = '0; m_rd = '0; m_dt = 0; m_dtrej = '0;
  endtask

  task automatic compare_all();
    check_eq("rd_valid", rd_valid, m_q.size() != 0);
    check_eq("level", level, m_q.size());
    check_eq("rd_data", rd_data, m_rd);
    check_eq("trg_count", trg_count, m_trg);
    check_eq("ovf_count", ovf_count, m_ovf);
`ifdef TRIGGER_STAMP_DEADTIME_EN
    check_eq("dt_reject", dt_reject_count, m_dtrej);
`endif
  endtask

  // one clock: advance the model with the current inputs, then compare after the edge
  task automatic step();
    logic [WW-1:0] w;
    bit ev, pop, blocked, written;
    ev = sync && enable && (trigger_in != 0);
    pop = (m_q.size() != 0) && rd_ready;
    blocked = 0;
    written = 0;
`ifdef TRIGGER_STAMP_DEADTIME_EN
    blocked = ev && (m_dt != 0);
    if (blocked) m_dtrej = m_dtrej + 16'd1;
`endif
    w = {trigger_in, m_bx, trigger_pos};
    if (pop) void'(m_q.pop_front());
    if (ev && !blocked) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(w);
        m_trg = m_trg + 16'd1;
        written = 1;
      end else if (m_ovf != 8'd255) begin
        m_ovf = m_ovf + 8'd1;
      end
    end
    if (written) m_dt = int'(deadtime);
    else if (sync && m_dt != 0) m_dt--;
    if (clear_ts) m_bx = '0;
    else if (sync) m_bx = m_bx + 1'b1;
    if (m_q.size() != 0) m_rd = m_q[0];
    @(posedge clk80);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    sync = 0; enable = 1; clear_ts = 0; trigger_in = '0; trigger_pos = '0; rd_ready = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check_eq("rst_level", level, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_data", rd_data, 0);
    model_reset();
    idle_inputs();
    @(posedge clk80);
    #1;
    reset_n = 1;
  endtask

  task automatic sync_trig(input logic [4:0] t, input logic [3:0] p);
    sync = 1; trigger_in = t; trigger_pos = p;
    step();
    sync = 0; trigger_in = '0;
  endtask

  int rp;

  initial begin
    model_reset();
    idle_inputs();
    @(posedge clk80);
    #1;
    check_eq("rst_trg", trg_count, 0);
    check_eq("rst_ovf", ovf_count, 0);
    check_eq("rst_level0", level, 0);
    reset_n = 1;

    // timestamp wrap on the 4-bit instance
    w_sync = 1;
    for (int i = 0; i < 15; i++) begin @(posedge clk80); #1; end
    w_trig = 5'b00010; w_pos = 4'd1;
    @(posedge clk80); #1;
    @(posedge clk80); #1;
    w_sync = 0; w_trig = '0;
    check_eq("wrap_bx15", w_rd_data[7:4], 4'd15);
    check_eq("wrap_level", w_level, 2);
    w_rd_ready = 1;
    @(posedge clk80); #1;
    w_rd_ready = 0;
    check_eq("wrap_bx0", w_rd_data[7:4], 4'd0);

    // timestamp and write latency
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sync = 1; step();
      sync = 0; step();
    end
    sync_trig(5'b00010, 4'd7);
    check_eq("lat_valid", rd_valid, 1);
    check_eq("lat_data", rd_data, {5'b00010, 23'd5, 4'd7});
    check_eq("lat_level", level, 1);
    check_eq("lat_trg", trg_count, 1);

    // full and overflow, then ordered drain
    do_reset();
    sync = 1; trigger_in = 5'b00001;
    for (int i = 0; i < 18; i++) begin trigger_pos = 4'(i); step(); end
    sync = 0; trigger_in = '0;
    check_eq("full_level", level, 16);
    check_eq("full_ovf", ovf_count, 2);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_bx", rd_data[TS_W+3:4], i);
      step();
    end
    check_eq("drain_level", level, 0);

    // full with simultaneous pop
    rd_ready = 0;
    for (int i = 0; i < 16; i++) sync_trig(5'b00100, 4'd1);
    rd_ready = 1;
    sync_trig(5'b01000, 4'hA);
    check_eq("fullpop_level", level, 16);
    check_eq("fullpop_ovf", ovf_count, 2);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("fullpop_last", rd_data[3:0], 4'hA);
      step();
    end

    // non-sync triggers and enable=0
    do_reset();
    trigger_in = 5'h1f;
    for (int i = 0; i < 3; i++) step();
    check_eq("nosync_level", level, 0);
    enable = 0; sync = 1; step();
    enable = 1; sync = 0; trigger_in = '0;
    check_eq("dis_level", level, 0);
    sync_trig(5'b00010, 4'd2);
    check_eq("dis_bx", rd_data[TS_W+3:4], 1);

    // clear_ts coinciding with an event
    do_reset();
    sync = 1;
    for (int i = 0; i < 100; i++) step();
    clear_ts = 1;
    sync_trig(5'b00100, 4'd3);
    clear_ts = 0;
    sync_trig(5'b00100, 4'd4);
    check_eq("clr_old_bx", rd_data[TS_W+3:4], 100);
    rd_ready = 1; step(); rd_ready = 0;
    check_eq("clr_new_bx", rd_data[TS_W+3:4], 0);

    // reset mid-burst
    for (int i = 0; i < 5; i++) sync_trig(5'b10000, 4'd5);
    do_reset();

`ifdef TRIGGER_STAMP_DEADTIME_EN
    deadtime = 8'd3;
    for (int i = 0; i < 5; i++) sync_trig(5'b00010, 4'(i));
    check_eq("dt_level", level, 2);
    check_eq("dt_reject", dt_reject_count, 3);
    check_eq("dt_second_bx", rd_data[TS_W+3:4], 0);
    deadtime = 8'd0;
`endif

    // randomized traffic
    rp = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rp = (i % 600 == 0) ? 10 : ((i % 400 == 0) ? 90 : 50);
      if ($urandom_range(0, 799) == 0) do_reset();
      sync = ($urandom_range(0, 2) != 0);
      enable = ($urandom_range(0, 9) != 0);
      clear_ts = ($urandom_range(0, 49) == 0);
      trigger_in = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      trigger_pos = 4'($urandom);
      rd_ready = ($urandom_range(0, 99) < rp);
`ifdef TRIGGER_STAMP_DEADTIME_EN
      deadtime = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_stamp_fifo.md
Name: trigger_stamp_fifo

Overview:
- Sits directly downstream of the asynchronous trigger sampler, in the clk80 domain.
- Consumes the per-sync trigger vector and its 4-bit fine position, timestamps each trigger with a bunch-crossing counter, and buffers the event words in a FIFO.
- Event words leave through a valid/ready read port toward the readout/DAQ logic.
- Keeps accepted-trigger and overflow statistics.

Parameters:
TS_W, 23, width of the bunch-crossing timestamp counter (event word = 5+TS_W+4 bits, 32 at default)
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries at default)

Ports:
clk80  in  1  system clock, 80 MHz, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sync  in  1  one-cycle qualifier marking bunch-crossing boundaries; trigger_in/trigger_pos are valid only when high
enable  in  1  1 = accept triggers; 0 = discard (timestamp keeps counting)
clear_ts  in  1  synchronous clear of the timestamp counter
trigger_in  in  5  trigger source vector from sampler (bit1 = external trigger)
trigger_pos  in  4  fine position of the trigger within the sync period
rd_valid  out  1  head event word available
rd_ready  in  1  consumer accepts head word
rd_data  out  9+TS_W  event word {trigger_in[4:0], bx[TS_W-1:0], trigger_pos[3:0]}
level  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2
trg_count  out  16  accepted-event counter
ovf_count  out  8  events dropped because the FIFO was full

Behaviour:
- Reset (reset_n low, async): bx=0, FIFO empty, rd_valid=0, rd_data=0, level=0, trg_count=0, ovf_count=0. Reset mid-operation discards all stored words.
- Timestamp bx:
  - Increments by 1 at each clock edge where sync=1.
  - Wraps from 2^TS_W-1 to 0.
  - clear_ts=1 forces bx=0 at the next edge, overriding any increment in the same cycle.
- Event detect: event = sync && enable && (trigger_in != 0). Cycles with sync=0 are ignored, so an upstream value held between syncs never duplicates an event.
- Captured word:
  - trigger_in and trigger_pos as sampled in the event cycle.
  - bx value before that cycle's increment (the register value, not bx+1).
  - If clear_ts coincides with an event, the word carries the old bx.
- Write: the word is written at the edge closing the event cycle. Latency into an empty FIFO: rd_valid=1 and rd_data valid one cycle after the event cycle.
- Read handshake:
  - rd_valid = (level != 0). rd_data = head word, stable while rd_valid=1 and rd_ready=0.
  - Pop on rd_valid && rd_ready.
  - With level=0, rd_data holds its last value and rd_ready is ignored.
- Full boundary:
  - If level = 2^DEPTH_LOG2 and an event occurs without a simultaneous pop, the word is dropped.
  - A drop increments ovf_count, saturating at 255. trg_count is not incremented.
  - If the FIFO is full and a pop occurs in the event cycle, the write is accepted and level is unchanged.
- Empty boundary: simultaneous write and pop are not possible when empty (rd_valid=0). The write proceeds and level becomes 1.
- level: +1 on write only, -1 on pop only, unchanged on both. Pointers wrap modulo 2^DEPTH_LOG2.
- trg_count: +1 per word actually written, 16-bit wrap.
- enable=0: no writes, no counter changes except bx. Reading continues normally.

Optional Feature:
- Macro: TRIGGER_STAMP_DEADTIME_EN.
- When defined, adds two ports:
  - deadtime in 8: minimum spacing in sync periods.
  - dt_reject_count out 16: count of dead-time rejections.
- Dead-time counter:
  - Loaded with deadtime on each written event.
  - Decrements by 1 on each later sync while nonzero.
  - Events arriving while the counter is nonzero are rejected: not written, dt_reject_count +1 (16-bit wrap), ovf_count unchanged.
  - An event dropped for FIFO full does not load the counter.
  - deadtime=0 disables suppression. Reset clears both the counter and dt_reject_count.
- When undefined: no extra ports; every detected event goes to the full check.

Test Plan:
- Timestamp/latency: reset, sync every 2nd cycle, 5 syncs, then trigger_in=5'b00010, trigger_pos=4'd7 on the 6th sync → one cycle later rd_valid=1, rd_data={5'b00010, 23'd5, 4'd7}, level=1, trg_count=1.
- Full/overflow: rd_ready=0, 18 consecutive sync triggers → level=16, ovf_count=2. Then rd_ready=1 for 16 cycles → words read in order with bx 0..15, level=0.
- Full with simultaneous pop: FIFO full, rd_ready=1, event in same cycle → level stays 16, ovf_count unchanged, new word appears last.
- Non-sync and enable: trigger_in held nonzero for 3 cycles with sync=0 → no write. enable=0 on a sync with trigger → no write, bx still increments.
- clear_ts with event: bx=100, clear_ts and event in same sync cycle → word bx=100, next event's bx=0. Set bx to 2^23-1 and apply one sync → bx=0. Assert reset_n low mid-burst → level=0 and rd_valid=0 immediately.
- With TRIGGER_STAMP_DEADTIME_EN: deadtime=3, triggers on 5 consecutive syncs → words written for syncs 1 and 5 only, dt_reject_count=3.
